// File: rtl/stream_demux.sv
// One-to-NUM_ELEM packet demultiplexer with per-channel output registers.
// Optional beat counters: define STREAM_DEMUX_BEAT_CNT_EN.
module stream_demux #(
  parameter int NUM_ELEM   = 8,
  parameter int ELEM_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                                 clk_i,
  input  logic                                 arst_ni,
  input  logic [$clog2(NUM_ELEM)-1:0]          sel_i,
  input  logic                                 in_valid_i,
  output logic                                 in_ready_o,
  input  logic [ELEM_WIDTH-1:0]                in_data_i,
  input  logic                                 in_last_i,
  output logic [NUM_ELEM-1:0]                  out_valid_o,
  input  logic [NUM_ELEM-1:0]                  out_ready_i,
  output logic [NUM_ELEM-1:0][ELEM_WIDTH-1:0]  out_data_o,
  output logic [NUM_ELEM-1:0]                  out_last_o,
  output logic                                 sel_err_o,
  input  logic                                 cnt_clr_i,
  output logic [NUM_ELEM-1:0][CNT_WIDTH-1:0]   beat_cnt_o
);

  localparam int SW = $clog2(NUM_ELEM);

  typedef enum logic [1:0] {
    IDLE,
    LOCKED,
    DROP
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [SW-1:0] lock_sel;
  logic [SW-1:0] eff;
  logic          sel_ok;
  logic          rdy_eff;
  logic          accept;
  logic          route;
  logic          lock_ld;
  logic          err_set;

  // Power-of-two channel counts cannot see an out-of-range selector.
  if (NUM_ELEM == (1 << SW)) begin : g_sel_full
    assign sel_ok = 1'b1;
  end else begin : g_sel_part
    assign sel_ok = ({1'b0, sel_i} < (SW+1)'(NUM_ELEM));
  end

  assign eff     = (state == LOCKED) ? lock_sel : sel_i;
  assign rdy_eff = ~out_valid_o[eff] | out_ready_i[eff];
  assign accept  = in_valid_i & in_ready_o;

  always_comb begin
    state_nx   = state;
    in_ready_o = 1'b0;
    route      = 1'b0;
    lock_ld    = 1'b0;
    err_set    = 1'b0;
    unique case (state)
      IDLE: begin
        if (sel_ok) begin
          in_ready_o = rdy_eff;
          route      = in_valid_i & rdy_eff;
          if (route && !in_last_i) begin
            state_nx = LOCKED;
            lock_ld  = 1'b1;
          end
        end else begin
          in_ready_o = 1'b1;
          err_set    = in_valid_i;
          if (in_valid_i && !in_last_i) begin
            state_nx = DROP;
          end
        end
      end
      LOCKED: begin
        in_ready_o = rdy_eff;
        route      = in_valid_i & rdy_eff;
        if (route && in_last_i) begin
          state_nx = IDLE;
        end
      end
      DROP: begin
        in_ready_o = 1'b1;
        if (accept && in_last_i) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state     <= IDLE;
      lock_sel  <= '0;
      sel_err_o <= 1'b0;
    end else begin
      state <= state_nx;
      if (lock_ld) begin
        lock_sel <= sel_i;
      end
      if (err_set) begin
        sel_err_o <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      out_valid_o <= '0;
      out_data_o  <= '0;
      out_last_o  <= '0;
    end else begin
      for (int i = 0; i < NUM_ELEM; i++) begin
        if (route && eff == SW'(i)) begin
          out_valid_o[i] <= 1'b1;
          out_data_o[i]  <= in_data_i;
          out_last_o[i]  <= in_last_i;
        end else if (out_ready_i[i]) begin
          out_valid_o[i] <= 1'b0;
        end
      end
    end
  end

`ifdef STREAM_DEMUX_BEAT_CNT_EN
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      beat_cnt_o <= '0;
    end else begin
      for (int i = 0; i < NUM_ELEM; i++) begin
        if (cnt_clr_i) begin
          beat_cnt_o[i] <= '0;
        end else if (route && eff == SW'(i) && beat_cnt_o[i] != '1) begin
          beat_cnt_o[i] <= beat_cnt_o[i] + CNT_WIDTH'(1);
        end
      end
    end
  end
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr_i;
  assign beat_cnt_o     = '0;
`endif

endmodule

// File: doc/stream_demux.md
STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 SHALL have parameter NUM_ELEM, default 8: number of output channels, range 2..256.
REQ-002 SHALL have parameter ELEM_WIDTH, default 32: data bits per beat.
REQ-003 SHALL have parameter CNT_WIDTH, default 16: width of each per-channel beat counter.
REQ-004 SHALL have one clock and an asynchronous active-low reset, named as follows.
- clk_i  in  1  clock; all state updates on the rising edge.
- arst_ni  in  1  asynchronous active-low reset.
REQ-005 SHALL have the following ports.
- sel_i  in  $clog2(NUM_ELEM)  destination channel; sampled only on the first beat of a packet.
- in_valid_i  in  1  input beat valid.
- in_ready_o  out  1  input beat accepted when in_valid_i and in_ready_o are both high.
- in_data_i  in  ELEM_WIDTH  input beat data.
- in_last_i  in  1  last beat of the packet.
- out_valid_o  out  NUM_ELEM  per-channel valid.
- out_ready_i  in  NUM_ELEM  per-channel ready.
- out_data_o  out  NUM_ELEM x ELEM_WIDTH  per-channel data.
- out_last_o  out  NUM_ELEM  per-channel last.
- sel_err_o  out  1  sticky flag: an out-of-range selector was seen.
- cnt_clr_i  in  1  synchronous clear of the beat counters.
- beat_cnt_o  out  NUM_ELEM x CNT_WIDTH  per-channel accepted-beat counts.

Function
REQ-006 SHALL implement a three-state FSM: IDLE, LOCKED, DROP.
REQ-007 SHALL define the effective selector as follows: in IDLE it is sel_i; in LOCKED it is the registered lock_sel.
REQ-008 In IDLE, an accepted beat with sel_i < NUM_ELEM and in_last_i=0 SHALL load lock_sel with sel_i and move the FSM to LOCKED.
REQ-009 In IDLE, an accepted beat with in_last_i=1 SHALL leave the FSM in IDLE, so single-beat packets cause no lock.
REQ-010 In LOCKED, sel_i SHALL be ignored, and an accepted beat with in_last_i=1 SHALL return the FSM to IDLE.
REQ-011 In IDLE, a beat with sel_i >= NUM_ELEM SHALL be handled as follows.
- in_ready_o = 1; the beat is discarded.
- sel_err_o is set.
- If in_last_i=0, the FSM moves to DROP.
REQ-012 In DROP, in_ready_o SHALL be 1, all beats SHALL be discarded, and an accepted beat with in_last_i=1 SHALL return the FSM to IDLE.
REQ-013 Each channel SHALL have a one-entry output register holding data, last and valid.
REQ-014 In IDLE and LOCKED, in_ready_o SHALL equal !out_valid_o[eff] | out_ready_i[eff].
- Throughput: one beat per cycle per channel when ready is held high.
REQ-015 An accepted beat SHALL appear on out_data_o[eff], out_last_o[eff] and out_valid_o[eff]=1 on the following cycle (latency 1).
REQ-016 out_valid_o[i] SHALL clear after an out_ready_i[i] handshake unless a new beat for channel i is accepted in the same cycle; if one is, it is reloaded and stays high.
REQ-017 Non-selected channels SHALL be unaffected: their data and last hold, and their valid changes only through their own handshake.
REQ-018 The input SHALL be stable under backpressure: in_ready_o=0 consumes nothing, and routing is unchanged while the FSM is LOCKED.
REQ-019 sel_err_o SHALL remain high until reset.

Reset
REQ-020 Asserting arst_ni low SHALL immediately force the following, regardless of the clock.
- FSM = IDLE, lock_sel = 0.
- out_valid_o = 0, out_data_o = 0, out_last_o = 0.
- sel_err_o = 0, beat_cnt_o = 0.
REQ-021 A reset asserted mid-packet SHALL abandon the packet, and the first accepted beat after reset SHALL be treated as a packet start.
REQ-022 Deassertion of arst_ni SHALL be synchronised externally; the block SHALL require no reset-release cycles.

Configuration
REQ-023 Macro STREAM_DEMUX_BEAT_CNT_EN SHALL control the beat counters.
- Defined: beat_cnt_o[i] increments on each accepted beat routed to channel i (discarded beats are not counted).
- Defined: the counters saturate at 2^CNT_WIDTH-1.
- Defined: cnt_clr_i=1 zeroes all counters, with priority over increment.
- Not defined: beat_cnt_o is tied to 0, cnt_clr_i is ignored, and no counter flops exist.

Verification
REQ-024 Single-beat packets: sel_i=3, data 0xA5A5_0001, last=1, all readies high.
- Expect: out_valid_o[3]=1 and out_data_o[3]=0xA5A5_0001 one cycle later.
- Expect: FSM remains IDLE.
REQ-025 Locked packet: 4 beats, sel_i=2 on beat 0, sel_i=5 on beats 1-3, last on beat 3.
- Expect: all 4 beats appear on channel 2; channel 5 is never valid.
REQ-026 Backpressure: out_ready_i[1]=0 with two beats for channel 1.
- Expect: first beat held; in_ready_o=0 on the second.
- After out_ready_i[1]=1: both beats delivered in order, with no loss or duplicate.
REQ-027 Out-of-range selector: NUM_ELEM=6, sel_i=7, 3-beat packet.
- Expect: in_ready_o=1 throughout, no out_valid_o asserted, sel_err_o=1 sticky.
- Expect: FSM back in IDLE after the last beat.
REQ-028 Reset mid-packet: arst_ni low after beat 1 of a 4-beat packet to channel 0.
- Expect: all outputs 0 immediately.
- Expect: the next beat with sel_i=4, last=1 lands on channel 4.
REQ-029 With STREAM_DEMUX_BEAT_CNT_EN, CNT_WIDTH=2: 5 beats to channel 0 gives beat_cnt_o[0]=3 (saturated); cnt_clr_i pulse gives 0.
